// File: rtl/multiple_adder_tree_pipelined.sv
// multiple_adder_tree_pipelined
// Pipelined multi-operand adder. N_OPS operands of WIDTH bits are reduced by a
// binary adder tree with one register level per tree level (latency LVL), and
// both sides use valid/ready handshakes with full backpressure and no bubbles.
// Optional feature, enabled by defining ADDER_TREE_ACCUM_EN: an in_last port
// and a final accumulator stage that emits one summed result per group.
module multiple_adder_tree_pipelined #(
   parameter int  N_OPS  = 4,
   parameter int  WIDTH  = 32,
   parameter int  SIGNED = 0,
`ifdef ADDER_TREE_ACCUM_EN
   parameter int  ACC_W  = WIDTH + $clog2(N_OPS) + 8,
`endif
   localparam int LVL    = $clog2(N_OPS),
   localparam int OUT_W  = WIDTH + LVL
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [N_OPS*WIDTH-1:0] in_data,
`ifdef ADDER_TREE_ACCUM_EN
   input  logic                   in_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ACC_W-1:0]       out_sum
`else
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [OUT_W-1:0]       out_sum
`endif
);

   // The tree only balances for a power-of-two operand count.
   generate
      if (N_OPS < 2 || (1 << LVL) != N_OPS) begin : g_bad_n_ops
         $error("multiple_adder_tree_pipelined: N_OPS must be a power of two >= 2");
      end
   endgenerate

   logic [LVL:1] v_q;        // stage k holds a valid partial-sum set
   logic [LVL:1] v_in;       // valid offered to stage k by its upstream
   logic [LVL:1] adv;        // stage k may load this cycle
   logic         tail_ready; // the stage after the tree can take a result

   // Upstream valid per stage: in_valid feeds level 1, level k-1 feeds level k.
   assign v_in = LVL'({v_q, in_valid});

   // Ready chain: a stage may advance when the tail drains or any stage at or
   // after it is empty, so a full pipeline still accepts while emitting.
   always_comb begin
      logic open;
      // NOTE: every variable written here gets a value before any condition,
      // otherwise the tool infers a latch to hold the old value.
      open = 1'b0;
      adv  = '0;
      for (int k = 1; k <= LVL; k++) begin
         open = tail_ready;
         for (int j = k; j <= LVL; j++) begin
            open = open | ~v_q[j];
         end
         adv[k] = open;
      end
   end

   assign in_ready = adv[1];

   // Stage valid flags: each stage takes its upstream valid when it advances.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every stage
      // samples its upstream's pre-edge value regardless of statement order.
      if (rst) begin
         v_q <= '0;
      end else begin
         for (int k = 1; k <= LVL; k++) begin
            if (adv[k]) begin
               v_q[k] <= v_in[k];
            end
         end
      end
   end

   genvar k;
   generate
      for (k = 1; k <= LVL; k++) begin : g_lvl
         localparam int IW = WIDTH + k - 1; // width of this level's inputs
         localparam int OW = WIDTH + k;     // width of this level's sums
         localparam int NS = N_OPS >> k;    // partial sums held at this level

         logic [2*NS*IW-1:0] src;
         logic [NS*OW-1:0]   sum_d;
         logic [NS*OW-1:0]   sum_q;

         if (k == 1) begin : g_src_in
            assign src = in_data;
         end else begin : g_src_lvl
            assign src = g_lvl[k-1].sum_q;
         end

         // Pairwise add: each input widens by one bit (zero or sign) first.
         always_comb begin
            logic [IW-1:0] op_a;
            logic [IW-1:0] op_b;
            op_a  = '0;
            op_b  = '0;
            sum_d = '0;
            for (int i = 0; i < NS; i++) begin
               op_a = src[(2*i)*IW +: IW];
               op_b = src[(2*i+1)*IW +: IW];
               sum_d[i*OW +: OW] = {(SIGNED != 0) & op_a[IW-1], op_a}
                                 + {(SIGNED != 0) & op_b[IW-1], op_b};
            end
         end

         // Level register: loads an accepted upstream set, otherwise holds.
         always_ff @(posedge clk or posedge rst) begin
            // NOTE: these are plain datapath registers, not a memory array,
            // so they are cleared by reset to give a defined out_sum of 0.
            if (rst) begin
               sum_q <= '0;
            end else if (adv[k] && v_in[k]) begin
               sum_q <= sum_d;
            end
         end
      end
   endgenerate

`ifdef ADDER_TREE_ACCUM_EN
   logic [LVL:1]     last_q;   // group-end flag travelling with each set
   logic [LVL:1]     last_in;
   logic [OUT_W-1:0] tree_sum;
   logic [ACC_W-1:0] tree_ext;
   logic [ACC_W-1:0] acc_base;
   logic [ACC_W-1:0] acc_d;
   logic [ACC_W-1:0] acc_q;
   logic             ov_d;
   logic             ov_q;

   assign last_in  = LVL'({last_q, in_last});
   assign tree_sum = g_lvl[LVL].sum_q;
   assign tail_ready = out_ready | ~ov_q;

   // Last flags move in lock-step with the partial sums they belong to.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q <= '0;
      end else begin
         for (int j = 1; j <= LVL; j++) begin
            if (adv[j] && v_in[j]) begin
               last_q[j] <= last_in[j];
            end
         end
      end
   end

   // Next accumulator state: restart from zero right after an emitted total.
   always_comb begin
      tree_ext = {{(ACC_W-OUT_W){(SIGNED != 0) & tree_sum[OUT_W-1]}}, tree_sum};
      acc_base = ov_q ? '0 : acc_q;
      acc_d    = acc_base;
      ov_d     = 1'b0;
      if (v_q[LVL]) begin
         acc_d = acc_base + tree_ext;
         ov_d  = last_q[LVL];
      end
   end

   // Accumulator / output register: frozen while the output is stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
         ov_q  <= 1'b0;
      end else if (tail_ready) begin
         acc_q <= acc_d;
         ov_q  <= ov_d;
      end
   end

   assign out_valid = ov_q;
   assign out_sum   = acc_q;
`else
   // The last tree level is the output register; no logic follows it.
   assign tail_ready = out_ready;
   assign out_valid  = v_q[LVL];
   assign out_sum    = g_lvl[LVL].sum_q;
`endif

endmodule
